// File: rtl/rom_blit_pkg.sv
// Shared state encoding and default geometry for the ROM blitter.
// Types and constants only; no timing or backpressure of its own.
package rom_blit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2
    } blit_state_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;

endpackage

// File: rtl/rom_blit_if.sv
// Request, ROM and plot signals of the blitter as one bundle.
// slave = blitter side, master = requester/ROM/VGA side; no backpressure, iStart is a pulse.
interface rom_blit_if
    import rom_blit_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int ADDR_W   = 15
);
    logic                iStart;
    logic                iMode;
    logic [X_W-1:0]      iOrgX;
    logic [Y_W-1:0]      iOrgY;
    logic [COLOUR_W-1:0] iFillColour;
    logic [ADDR_W-1:0]   oRomAddr;
    logic [COLOUR_W-1:0] iRomData;
    logic [X_W-1:0]      oX;
    logic [Y_W-1:0]      oY;
    logic [COLOUR_W-1:0] oColour;
    logic                oPlot;
    logic                oBusy;
    logic                oDone;

    modport slave (
        input  iStart, iMode, iOrgX, iOrgY, iFillColour, iRomData,
        output oRomAddr, oX, oY, oColour, oPlot, oBusy, oDone
    );

    modport master (
        output iStart, iMode, iOrgX, iOrgY, iFillColour, iRomData,
        input  oRomAddr, oX, oY, oColour, oPlot, oBusy, oDone
    );
endinterface

// File: rtl/blit_raster_counter.sv
// Row-major col/row scan over the image; advances one pixel per enabled cycle.
// Holds at the last pixel until cleared; no backpressure beyond the enable.
module blit_raster_counter #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           clr,
    input  logic           en,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row,
    output logic           last
);
    localparam logic [X_W-1:0] COL_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] ROW_MAX = Y_W'(IMG_H - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en && !last) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rom_blit.sv
// Copies an IMG_W x IMG_H ROM image (or a solid fill) to the VGA plot port; plot 2 cycles after address.
// One pixel per cycle, no backpressure; ROM_BLIT_TRANSPARENCY_EN makes KEY_COLOUR pixels transparent.
module rom_blit
    import rom_blit_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int COLOUR_W   = DEF_COLOUR_W,
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int ADDR_W     = 15,
    parameter int KEY_COLOUR = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    rom_blit_if.slave  bus
);
`ifdef ROM_BLIT_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    blit_state_t         state;
    logic                mode_q;
    logic [X_W-1:0]      org_x;
    logic [Y_W-1:0]      org_y;
    logic [COLOUR_W-1:0] fill_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                flush_q;

    logic [X_W-1:0]      col;
    logic [Y_W-1:0]      row;
    logic                last;

    // Stage 1: coordinates of the pixel whose ROM word arrives this cycle.
    logic                valid1;
    logic [X_W-1:0]      col1;
    logic [Y_W-1:0]      row1;

    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                visible;
    logic                key_hit;

    blit_raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_counter (
        .Clock (Clock),
        .Reset (Reset),
        .clr   ((state == ST_IDLE) && bus.iStart),
        .en    (state == ST_DRAW),
        .col   (col),
        .row   (row),
        .last  (last)
    );

    // One extra bit so off-screen sums are clipped rather than wrapped.
    assign sum_x   = {1'b0, org_x} + {1'b0, col1};
    assign sum_y   = {1'b0, org_y} + {1'b0, row1};
    assign visible = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    assign key_hit = TRANSP_EN && !mode_q && (bus.iRomData == COLOUR_W'(KEY_COLOUR));

    assign bus.oRomAddr = addr_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            mode_q      <= 1'b0;
            org_x       <= '0;
            org_y       <= '0;
            fill_q      <= '0;
            addr_q      <= '0;
            flush_q     <= 1'b0;
            valid1      <= 1'b0;
            col1        <= '0;
            row1        <= '0;
            bus.oX      <= '0;
            bus.oY      <= '0;
            bus.oColour <= '0;
            bus.oPlot   <= 1'b0;
            bus.oBusy   <= 1'b0;
            bus.oDone   <= 1'b0;
        end else begin
            bus.oDone <= 1'b0;
            bus.oPlot <= valid1 && visible && !key_hit;
            valid1    <= (state == ST_DRAW);
            col1      <= col;
            row1      <= row;
            if (valid1) begin
                bus.oX      <= sum_x[X_W-1:0];
                bus.oY      <= sum_y[Y_W-1:0];
                bus.oColour <= mode_q ? fill_q : bus.iRomData;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.iStart) begin
                        mode_q    <= bus.iMode;
                        org_x     <= bus.iOrgX;
                        org_y     <= bus.iOrgY;
                        fill_q    <= bus.iFillColour;
                        addr_q    <= '0;
                        flush_q   <= 1'b0;
                        bus.oBusy <= 1'b1;
                        state     <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (last) begin
                        state <= ST_FLUSH;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Two cycles: ROM read of the last pixel, then its plot cycle.
                    if (flush_q) begin
                        state     <= ST_IDLE;
                        bus.oBusy <= 1'b0;
                        bus.oDone <= 1'b1;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_blit.sv
// Directed bench for rom_blit with a 4x2 image and a synchronous ROM holding address[2:0].
// Copy, clip, fill, ignored restart and mid-blit reset scenarios.
module tb_rom_blit;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef ROM_BLIT_TRANSPARENCY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    rom_blit_if #(.X_W(8), .Y_W(7), .COLOUR_W(3), .ADDR_W(3)) bus ();

    rom_blit #(
        .IMG_W  (4),
        .IMG_H  (2),
        .ADDR_W (3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) bus.iRomData <= bus.oRomAddr[2:0];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"},   int'(bus.oRomAddr), 0);
        check({tag, ".x"},      int'(bus.oX), 0);
        check({tag, ".y"},      int'(bus.oY), 0);
        check({tag, ".colour"}, int'(bus.oColour), 0);
        check({tag, ".plot"},   int'(bus.oPlot), 0);
        check({tag, ".busy"},   int'(bus.oBusy), 0);
        check({tag, ".done"},   int'(bus.oDone), 0);
    endtask

    // Cycle c counts from the first DRAW cycle; pixel k plots in cycle k+2, oDone in cycle 10.
    task automatic run_blit(input string tag, input bit mode, input int ox, input int oy,
                            input int fill, input bit restart, input int n_exp);
        int plots = 0;
        @(negedge Clock);
        bus.iStart      = 1'b1;
        bus.iMode       = mode;
        bus.iOrgX       = 8'(ox);
        bus.iOrgY       = 7'(oy);
        bus.iFillColour = 3'(fill);
        for (int c = 0; c < 12; c++) begin
            int k;
            int ex;
            int ey;
            int ecol;
            int eplot;
            @(negedge Clock);
            bus.iStart = restart && (c == 2);
            if (restart && c == 2) begin
                bus.iOrgX = 8'd0;
                bus.iOrgY = 7'd0;
                bus.iMode = ~mode;
            end
            k     = c - 2;
            ex    = ox + (k % 4);
            ey    = oy + (k / 4);
            ecol  = mode ? fill : k;
            eplot = 0;
            if (k >= 0 && k < 8 && ex < 160 && ey < 120 && !(KEY_EN && !mode && ecol == 0))
                eplot = 1;
            check({tag, ".plot"}, int'(bus.oPlot), eplot);
            if (eplot == 1) begin
                plots++;
                check({tag, ".x"},      int'(bus.oX), ex);
                check({tag, ".y"},      int'(bus.oY), ey);
                check({tag, ".colour"}, int'(bus.oColour), ecol);
            end
            if (c < 8) check({tag, ".addr"}, int'(bus.oRomAddr), c);
            check({tag, ".busy"}, int'(bus.oBusy), (c <= 9) ? 1 : 0);
            check({tag, ".done"}, int'(bus.oDone), (c == 10) ? 1 : 0);
        end
        check({tag, ".count"}, plots, n_exp);
        bus.iStart = 1'b0;
    endtask

    initial begin
        int done_seen;
        int plot_seen;
        bus.iStart      = 1'b0;
        bus.iMode       = 1'b0;
        bus.iOrgX       = 8'd0;
        bus.iOrgY       = 7'd0;
        bus.iFillColour = 3'd0;

        repeat (2) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("idle.busy", int'(bus.oBusy), 0);

        run_blit("copy",    1'b0, 10, 5,   0, 1'b0, KEY_EN ? 7 : 8);
        run_blit("clip",    1'b0, 158, 119, 0, 1'b0, KEY_EN ? 1 : 2);
        run_blit("fill",    1'b1, 20, 30,  2, 1'b0, 8);
        run_blit("restart", 1'b0, 10, 5,   0, 1'b1, KEY_EN ? 7 : 8);

        // Abandon a blit right after its third plot.
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iMode  = 1'b0;
        bus.iOrgX  = 8'd10;
        bus.iOrgY  = 7'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            bus.iStart = 1'b0;
        end
        check("midrst.plot3", int'(bus.oPlot), 1);
        check("midrst.x3",    int'(bus.oX), 12);
        Reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge Clock);
        Reset = 1'b0;
        done_seen = 0;
        plot_seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge Clock);
            if (bus.oDone) done_seen++;
            if (bus.oPlot) plot_seen++;
        end
        check("midrst.no_done", done_seen, 0);
        check("midrst.no_plot", plot_seen, 0);

        run_blit("after_rst", 1'b0, 10, 5, 0, 1'b0, KEY_EN ? 7 : 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
